// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and load/store traffic.
// Define MEM_ARB_FAIR_EN to bound consecutive data grants while a fetch is waiting.
module mem_port_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int MAX_DSTREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [DATA_WIDTH-1:0] if_addr,
   input  logic                  if_flush,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_valid,
   input  logic                  d_rd,
   input  logic                  d_wr,
   input  logic [DATA_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [2:0]            d_size,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_valid,
   output logic                  stall_if,
   output logic                  stall_d,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [2:0]            mem_size,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [DATA_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [2:0]            r_size;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_if_rdata;
   logic                  r_if_valid;
   logic [DATA_WIDTH-1:0] r_d_rdata;
   logic                  r_d_valid;
   logic                  r_discard;

   logic w_quiet;
   logic w_d_req;
   logic w_f_req;
   logic w_fetch_pri;
   logic w_grant_d;
   logic w_grant_f;

   // A completion cycle grants nothing: the finishing requester's request is stale and the
   // idle gap keeps a continuously requesting data port from starving the arbitration rule.
   assign w_quiet   = ~r_if_valid & ~r_d_valid;
   assign w_d_req   = (d_rd | d_wr) & w_quiet;
   assign w_f_req   = if_req & ~if_flush & w_quiet;
   assign w_grant_d = (r_state == IDLE) & w_d_req & ~w_fetch_pri;
   assign w_grant_f = (r_state == IDLE) & w_f_req & ~w_grant_d;

`ifdef MEM_ARB_FAIR_EN
   localparam int                STREAK_W   = $clog2(MAX_DSTREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

   logic [STREAK_W-1:0] r_streak;

   assign w_fetch_pri = w_f_req & (r_streak == STREAK_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_streak <= '0;
      end else if (r_state == IDLE) begin
         if (w_grant_f || !if_req)
            r_streak <= '0;
         else if (w_grant_d && (r_streak != STREAK_MAX))
            r_streak <= r_streak + 1'b1;
      end
   end
`else
   // Strict data priority; MAX_DSTREAK only matters with fairness enabled.
   assign w_fetch_pri = (MAX_DSTREAK < 0);
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant_d)
               w_next = DATA;
            else if (w_grant_f)
               w_next = FETCH;
         end
         FETCH, DATA: begin
            if (mem_ready)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_size     <= '0;
         r_we       <= 1'b0;
         r_if_rdata <= '0;
         r_if_valid <= 1'b0;
         r_d_rdata  <= '0;
         r_d_valid  <= 1'b0;
         r_discard  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_if_valid <= 1'b0;
         r_d_valid  <= 1'b0;
         case (r_state)
            IDLE: begin
               r_discard <= 1'b0;
               if (w_grant_d) begin
                  r_addr  <= d_addr;
                  r_wdata <= d_wdata;
                  r_size  <= d_size;
                  r_we    <= d_wr;
               end else if (w_grant_f) begin
                  r_addr <= if_addr;
                  r_size <= 3'b010;
                  r_we   <= 1'b0;
               end
            end
            FETCH: begin
               if (if_flush)
                  r_discard <= 1'b1;
               if (mem_ready) begin
                  r_if_rdata <= mem_rdata;
                  r_if_valid <= ~(r_discard | if_flush);
               end
            end
            DATA: begin
               if (mem_ready) begin
                  if (!r_we)
                     r_d_rdata <= mem_rdata;
                  r_d_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req   = (r_state != IDLE);
   assign mem_we    = r_we & mem_req;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_size  = r_size;
   assign if_rdata  = r_if_rdata;
   assign if_valid  = r_if_valid;
   assign d_rdata   = r_d_rdata;
   assign d_valid   = r_d_valid;
   // Stalls are gated by reset so every output reads 0 while reset is held.
   assign stall_if  = rst & if_req & ~r_if_valid;
   assign stall_d   = rst & (d_rd | d_wr) & ~r_d_valid;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch requester (PC) and its MEM-stage data requester (load/store).
- Sits between the riscv core and the unified memory model.
- Issues one memory transaction at a time and returns read data or write completion to the granted requester.
- Drives per-requester stall lines that the pipeline uses to freeze IF or MEM while waiting.

Parameters:
- DATA_WIDTH, 32, width of addresses, write data and read data
- MAX_DSTREAK, 4, consecutive data grants allowed while a fetch waits (used only with MEM_ARB_FAIR_EN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  DATA_WIDTH  fetch address (pc)
- if_flush  in  1  discard the in-flight or pending fetch (branch mispredict/error)
- if_rdata  out  DATA_WIDTH  fetched instruction
- if_valid  out  1  one-cycle pulse, if_rdata valid
- d_rd  in  1  load request (memread_M)
- d_wr  in  1  store request (memwrite)
- d_addr  in  DATA_WIDTH  data address (alu_result)
- d_wdata  in  DATA_WIDTH  store data
- d_size  in  3  load_store_M encoding, passed through unchanged
- d_rdata  out  DATA_WIDTH  load data
- d_valid  out  1  one-cycle pulse, load data valid or store done
- stall_if  out  1  if_req & ~if_valid
- stall_d  out  1  (d_rd | d_wr) & ~d_valid
- mem_req  out  1  memory transaction active
- mem_we  out  1  write transaction
- mem_addr  out  DATA_WIDTH  latched address
- mem_wdata  out  DATA_WIDTH  latched store data
- mem_size  out  3  latched d_size; 3'b010 (word) for fetch
- mem_ready  in  1  memory completes the transaction this cycle
- mem_rdata  in  DATA_WIDTH  valid when mem_ready is high

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters and flags 0. Reset mid-transaction drops mem_req immediately, and no valid pulse follows.
- States: IDLE, FETCH, DATA.
- IDLE transitions:
  - A requester whose valid is high this cycle is ignored; its request is stale.
  - If d_rd|d_wr, latch d_addr, d_wdata and d_size, set mem_we=d_wr, and go to DATA.
  - Otherwise, if if_req & ~if_flush, latch if_addr and go to FETCH.
  - Data has strict priority over fetch.
  - d_rd and d_wr both high is treated as a write.
- FETCH/DATA: mem_req=1. Address, write data, size and write enable stay stable until mem_ready.
- On mem_ready in FETCH:
  - if_rdata<=mem_rdata.
  - if_valid<=1 unless a flush was seen during the transaction.
  - Go to IDLE.
- On mem_ready in DATA:
  - For a read, d_rdata<=mem_rdata; for a write, d_rdata holds.
  - d_valid<=1.
  - Go to IDLE.
- Valid pulses last exactly one cycle. mem_req is low in the IDLE cycle following completion, so back-to-back transactions are separated by at least one idle cycle.
- Latency with zero-wait memory (mem_ready asserted in the first mem_req cycle): request seen in IDLE at cycle N, mem_req at N+1, valid at N+2. Each memory wait cycle adds one.
- Flush:
  - if_flush in any FETCH cycle, including the mem_ready cycle, sets a discard flag.
  - The transaction still completes on the memory side, but if_valid is suppressed; the flag clears on return to IDLE.
  - if_flush in IDLE blocks the fetch grant that cycle only.
  - if_flush has no effect on DATA.
- stall_if and stall_d are combinational from inputs and registered valids.

Optional Feature:
- MEM_ARB_FAIR_EN defined:
  - A streak counter increments on each DATA grant made while if_req is high.
  - At count==MAX_DSTREAK, the next IDLE grant goes to a pending, unflushed fetch even if data is also requesting.
  - The counter resets to 0 on any FETCH grant or whenever if_req is low in IDLE.
- Not defined: no counter; strict data priority.

Test Plan:
- Zero-wait fetch: if_req=1, if_addr=0x100, mem_ready=1 on the first mem_req cycle, mem_rdata=0x00500093 -> mem_req high for 1 cycle with mem_addr=0x100 and mem_size=3'b010; if_valid pulses 2 cycles after the request with if_rdata=0x00500093.
- Contention: if_req=1 and d_rd=1 (d_addr=0x2000) in the same IDLE cycle -> DATA granted first (mem_addr=0x2000); fetch granted in the IDLE cycle after d_valid; stall_if high throughout.
- Store with 3 wait cycles: d_wr=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_size=3'b010 -> mem_we=1 and address/data stable for 4 mem_req cycles; single d_valid pulse; d_rdata unchanged.
- Flush in flight: fetch of 0x104, if_flush on the 2nd wait cycle -> transaction completes, no if_valid; a new fetch of 0x200 is then granted normally.
- Async reset mid-DATA: rst low for 1 cycle while mem_req=1 -> mem_req, d_valid and stall outputs drop to 0 immediately; state IDLE after release.
- MEM_ARB_FAIR_EN, MAX_DSTREAK=2: continuous d_rd plus if_req -> grant order DATA, DATA, FETCH, DATA, DATA, FETCH; without the macro, FETCH is never granted while d_rd stays high.
